// File: rtl/sigmoid_arbiter.sv
// -----------------------------------------------------------------------------
// sigmoid_arbiter
//
// Purpose:
//   Shares one combinational sigmoid_approx instance among NUM_REQ requesters
//   (for example parallel generator/discriminator neuron lanes). Requesters are
//   served round-robin with valid/ready handshakes. Every result is registered
//   and tagged with the index of the requester that produced it. The block sits
//   between the layer MAC outputs and the activation write-back buffer.
//
// Parameters:
//   NUM_REQ    number of requesters (>= 1)
//   DATA_WIDTH signed fixed-point sample width
//   Q_FRAC     fractional bits of the fixed-point format
//   SAT_LIMIT  input magnitude at which the sigmoid saturates
//   ID_W       response tag width, max(1, $clog2(NUM_REQ))
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   req_valid  per-requester request valid
//   req_data   packed samples, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-requester accept, one-hot or zero
//   resp_valid response valid
//   resp_data  sigmoid result, range [0, 1<<Q_FRAC]
//   resp_id    index of the requester that produced resp_data
//   resp_ready downstream accept
//
// Build option:
//   SIGMOID_ARB_SKID_EN  when defined, the output stage is a 2-entry FIFO and
//                        req_ready depends only on the registered entry count.
//                        When undefined, a single output register is used and
//                        req_ready depends combinationally on resp_ready.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sigmoid_approx
//
// Purpose:
//   Piecewise-linear sigmoid: y = 0.5 + x/4, clamped to [0, 1.0], and forced
//   to 0 / 1.0 once |x| reaches SAT_LIMIT. Purely combinational.
//
// Ports:
//   x  signed fixed-point input, Q_FRAC fractional bits
//   y  unsigned fixed-point output, Q_FRAC fractional bits
// -----------------------------------------------------------------------------
module sigmoid_approx #(
   parameter int DATA_WIDTH = 16,
   parameter int Q_FRAC     = 8,
   parameter int SAT_LIMIT  = 1024
) (
   input  logic signed [DATA_WIDTH-1:0] x,
   output logic        [DATA_WIDTH-1:0] y
);

   localparam int EW = DATA_WIDTH + 2;

   localparam logic signed [EW-1:0] SAT_POS = EW'(SAT_LIMIT);
   localparam logic signed [EW-1:0] SAT_NEG = -SAT_POS;
   localparam logic signed [EW-1:0] HALF_V  = EW'(1 << (Q_FRAC - 1));
   localparam logic signed [EW-1:0] ONE_V   = EW'(1 << Q_FRAC);

   logic signed [EW-1:0] x_ext;
   logic signed [EW-1:0] quarter;
   logic signed [EW-1:0] sum;

   // The input is widened by two bits so that adding 0.5 to x/4 can never
   // wrap. The arithmetic shift floors toward minus infinity; no rounding is
   // added. The result is clamped into [0, 1.0] after the hard saturation
   // thresholds are applied.
   always_comb begin
      x_ext   = EW'(x);
      quarter = x_ext >>> 2;
      sum     = quarter + HALF_V;
      if (x_ext >= SAT_POS) begin
         y = DATA_WIDTH'(ONE_V);
      end else if (x_ext <= SAT_NEG) begin
         y = '0;
      end else if (sum[EW-1]) begin
         y = '0;
      end else if (sum > ONE_V) begin
         y = DATA_WIDTH'(ONE_V);
      end else begin
         y = DATA_WIDTH'(sum);
      end
   end

endmodule

module sigmoid_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int Q_FRAC     = 8,
   parameter int SAT_LIMIT  = 1024,
   parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic [ID_W-1:0]               resp_id,
   input  logic                          resp_ready
);

   logic [ID_W-1:0]       rr_ptr;
   logic                  grant_found;
   logic [ID_W-1:0]       grant_idx;
   logic                  can_push;
   logic                  accept;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] sig_result;

   // Round-robin search: first pass covers indices at or above the pointer,
   // second pass wraps around to the indices below it. The grant is recomputed
   // every cycle, so a requester that drops valid simply stops being chosen.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i] && (ID_W'(i) < rr_ptr)) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(i);
         end
      end
   end

   // A grant only turns into an accept when the output stage has room and the
   // block is not in reset. The ready vector is therefore one-hot or zero.
   always_comb begin
      accept    = grant_found && can_push && !rst;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept && (grant_idx == ID_W'(i))) begin
            req_ready[i] = 1'b1;
         end
      end
   end

   // Select the granted requester's sample for the shared sigmoid unit.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   sigmoid_approx #(
      .DATA_WIDTH (DATA_WIDTH),
      .Q_FRAC     (Q_FRAC),
      .SAT_LIMIT  (SAT_LIMIT)
   ) u_sigmoid (
      .x (sel_data),
      .y (sig_result)
   );

   // The pointer moves to the slot after the requester just served, so that
   // requester becomes lowest priority. Without an accept it stays put.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept) begin
         if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= grant_idx + ID_W'(1);
         end
      end
   end

`ifdef SIGMOID_ARB_SKID_EN

   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic [ID_W-1:0]       fifo_id   [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic                  pop;

   // Ready comes from the registered count alone, which breaks the
   // combinational path from resp_ready back to the requesters. The second
   // entry absorbs the sample accepted in the cycle backpressure appears.
   always_comb begin
      can_push   = (count != 2'd2);
      resp_valid = (count != 2'd0);
      pop        = resp_valid && resp_ready;
      resp_data  = fifo_data[rd_ptr];
      resp_id    = fifo_id[rd_ptr];
   end

   // Two-entry FIFO. Entries are cleared on reset so the visible head reads
   // zero until the first result arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_id[0]   <= '0;
         fifo_id[1]   <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
      end else begin
         if (accept) begin
            fifo_data[wr_ptr] <= sig_result;
            fifo_id[wr_ptr]   <= grant_idx;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`else

   // The single register can take new data when it is empty or when its
   // current contents leave this cycle, so push and pop overlap without a
   // bubble. This makes req_ready depend combinationally on resp_ready.
   always_comb begin
      can_push = !resp_valid || resp_ready;
   end

   // Output register. Data and tag only change on an accept, so they hold
   // steady while the downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= '0;
      end else if (accept) begin
         resp_valid <= 1'b1;
         resp_data  <= sig_result;
         resp_id    <= grant_idx;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_arbiter
//
// Purpose:
//   Self-checking bench for sigmoid_arbiter (NUM_REQ=4, DATA_WIDTH=16,
//   Q_FRAC=8, SAT_LIMIT=1024). A table of hand-derived sigmoid vectors is
//   applied through requester 0, then short hand-written sequences cover
//   round-robin order, pointer wrap, backpressure, a dropped request and a
//   mid-operation reset. A scoreboard records every accept and checks every
//   response handshake against a reference sigmoid.
//
// Ports: none (top-level bench). Honours SIGMOID_ARB_SKID_EN.
// -----------------------------------------------------------------------------
module tb_sigmoid_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 16;
   localparam int ID_W    = 2;

`ifdef SIGMOID_ARB_SKID_EN
   localparam int EXTRA_ACCEPTS = 1;
   localparam int FILL_DEPTH    = 2;
`else
   localparam int EXTRA_ACCEPTS = 0;
   localparam int FILL_DEPTH    = 1;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  resp_valid;
   logic [DW-1:0]         resp_data;
   logic [ID_W-1:0]       resp_id;
   logic                  resp_ready;

   typedef struct {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
   } vec_t;

   typedef struct {
      logic [DW-1:0]   data;
      logic [ID_W-1:0] id;
   } exp_t;

   exp_t scoreboard[$];
   int   acceptLog[$];
   int   respLog[$];
   int   checkCount = 0;
   int   passCount  = 0;

   sigmoid_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DW),
      .Q_FRAC     (8),
      .SAT_LIMIT  (1024)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_ready (resp_ready)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point: every check steps the counters used in the
   // summary line.
   function automatic void check(input string name, input logic [31:0] actual,
                                 input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endfunction

   // Reference sigmoid: 0.5 + floor(x/4) in Q8, clamped to [0, 1.0], with hard
   // saturation at |x| >= 4.0.
   function automatic logic [DW-1:0] sigmoidModel(input logic [DW-1:0] x);
      int v;
      int q;
      int y;
      v = int'($signed(x));
      if (v >= 1024) return 16'h0100;
      if (v <= -1024) return 16'h0000;
      if (v >= 0) q = v / 4;
      else q = -((-v + 3) / 4);
      y = 128 + q;
      if (y < 0) y = 0;
      if (y > 256) y = 256;
      return y[DW-1:0];
   endfunction

   // Scoreboard monitor on the falling edge: pop and compare on each response
   // handshake, then push the expectation for each accept happening at the
   // coming rising edge. Reset discards anything outstanding.
   always @(negedge clk) begin
      if (rst) begin
         check("ready_in_reset", 32'(req_ready), 32'h0);
         scoreboard.delete();
      end else begin
         check("ready_onehot0", 32'($onehot0(req_ready)), 32'h1);
         if (resp_valid && resp_ready) begin
            if (scoreboard.size() == 0) begin
               check("unexpected_resp", 32'(resp_id), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = scoreboard.pop_front();
               check("sb_data", 32'(resp_data), 32'(e.data));
               check("sb_id", 32'(resp_id), 32'(e.id));
            end
            respLog.push_back(int'(resp_id));
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               scoreboard.push_back('{sigmoidModel(req_data[i*DW +: DW]), ID_W'(i)});
               acceptLog.push_back(i);
            end
         end
      end
   end

   // Inputs change one time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic observe(output logic [NUM_REQ-1:0] seen);
      @(negedge clk);
      seen = req_ready;
   endtask

   task automatic advance(input logic [NUM_REQ-1:0] seen);
      tick();
      req_valid = req_valid & ~seen;
   endtask

   task automatic applyStimulus(input int r, input logic [DW-1:0] x);
      req_valid[r]         = 1'b1;
      req_data[r*DW +: DW] = x;
   endtask

   task automatic doReset();
      rst        = 1'b1;
      req_valid  = '0;
      resp_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Hold every pending request until it is accepted, bounded by a budget.
   task automatic runUntilIdle(input int budget);
      logic [NUM_REQ-1:0] seen;
      int n;
      n = 0;
      while ((req_valid != '0) && (n < budget)) begin
         observe(seen);
         advance(seen);
         n++;
      end
      if (req_valid != '0) begin
         check("accept_timeout", 32'(req_valid), 32'h0);
         req_valid = '0;
      end
   endtask

   task automatic checkOutput(input string name, input logic [DW-1:0] expData,
                              input logic [ID_W-1:0] expId);
      @(negedge clk);
      check({name, "_valid"}, 32'(resp_valid), 32'h1);
      check({name, "_data"}, 32'(resp_data), 32'(expData));
      check({name, "_id"}, 32'(resp_id), 32'(expId));
      tick();
   endtask

   task automatic drain();
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         tick();
      end
      check("scoreboard_empty", 32'(scoreboard.size()), 32'h0);
   endtask

   // Hard time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t               vecs[12];
      logic [NUM_REQ-1:0] seen;
      logic [DW-1:0]      bpData[3];
      int                 nextIdx;
      int                 extra;
      int                 zeroTags;

      rst        = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      resp_ready = 1'b0;

      vecs[0]  = '{16'h0000, 16'h0080};
      vecs[1]  = '{16'h0100, 16'h00C0};
      vecs[2]  = '{16'hFF00, 16'h0040};
      vecs[3]  = '{16'h0400, 16'h0100};
      vecs[4]  = '{16'hFC00, 16'h0000};
      vecs[5]  = '{16'h0080, 16'h00A0};
      vecs[6]  = '{16'h03FF, 16'h0100};
      vecs[7]  = '{16'hFE00, 16'h0000};
      vecs[8]  = '{16'hFFFF, 16'h007F};
      vecs[9]  = '{16'h0001, 16'h0080};
      vecs[10] = '{16'h0200, 16'h0100};
      vecs[11] = '{16'hFD00, 16'h0000};

      // Reset state.
      doReset();
      observe(seen);
      check("reset_resp_valid", 32'(resp_valid), 32'h0);
      check("reset_resp_data", 32'(resp_data), 32'h0);
      check("reset_resp_id", 32'(resp_id), 32'h0);
      check("reset_ready", 32'(seen), 32'h0);
      tick();

      // Table vectors through requester 0, each result one cycle after accept.
      resp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, vecs[i].x);
         runUntilIdle(20);
         checkOutput($sformatf("vec%0d", i), vecs[i].y, 2'd0);
      end
      drain();

      // All four requesters valid: ids 0,1,2,3,0,1, one per cycle.
      doReset();
      resp_ready = 1'b1;
      applyStimulus(0, 16'h0000);
      applyStimulus(1, 16'h0100);
      applyStimulus(2, 16'hFF00);
      applyStimulus(3, 16'h0080);
      observe(seen);
      tick();
      for (int k = 0; k < 6; k++) begin
         observe(seen);
         check($sformatf("rr_valid%0d", k), 32'(resp_valid), 32'h1);
         check($sformatf("rr_id%0d", k), 32'(resp_id), 32'(k % 4));
         tick();
      end
      drain();

      // Requesters 1 and 3 with the pointer at 2: 3 first, then 1.
      doReset();
      resp_ready = 1'b1;
      applyStimulus(1, 16'h0100);
      runUntilIdle(20);
      acceptLog.delete();
      applyStimulus(1, 16'h0080);
      applyStimulus(3, 16'hFF00);
      runUntilIdle(20);
      check("wrap_count", 32'(acceptLog.size()), 32'd2);
      check("wrap_first", 32'(acceptLog[0]), 32'd3);
      check("wrap_second", 32'(acceptLog[1]), 32'd1);
      applyStimulus(0, 16'h0000);
      applyStimulus(1, 16'h0000);
      applyStimulus(2, 16'h0000);
      applyStimulus(3, 16'h0000);
      observe(seen);
      check("wrap_ptr_grant", 32'(seen), 32'b0100);
      advance(seen);
      runUntilIdle(20);
      drain();

      // Backpressure for three cycles while requester 2 keeps offering data.
      doReset();
      bpData[0] = 16'h0100;
      bpData[1] = 16'hFF00;
      bpData[2] = 16'h0080;
      nextIdx   = 1;
      extra     = 0;
      applyStimulus(2, bpData[0]);
      observe(seen);
      check("bp_first_accept", 32'(seen), 32'b0100);
      tick();
      for (int k = 0; k < 3; k++) begin
         observe(seen);
         check($sformatf("bp_valid%0d", k), 32'(resp_valid), 32'h1);
         check($sformatf("bp_data%0d", k), 32'(resp_data), 32'h00C0);
         check($sformatf("bp_id%0d", k), 32'(resp_id), 32'd2);
         if (seen[2]) extra++;
         tick();
         if ((seen[2] || (k == 0 && nextIdx == 1)) && (nextIdx < 3)) begin
            applyStimulus(2, bpData[nextIdx]);
            nextIdx++;
         end
      end
      check("bp_extra_accepts", 32'(extra), 32'(EXTRA_ACCEPTS));
      observe(seen);
      check("bp_ready_blocked", 32'(seen), 32'h0);
      tick();
      resp_ready = 1'b1;
      runUntilIdle(20);
      drain();

      // Requester 0 withdraws while blocked; requester 1 is served instead.
      doReset();
      for (int f = 0; f < FILL_DEPTH; f++) begin
         applyStimulus(3, 16'h0000);
         runUntilIdle(20);
      end
      acceptLog.delete();
      respLog.delete();
      applyStimulus(0, 16'h0400);
      applyStimulus(1, 16'h0100);
      for (int k = 0; k < 2; k++) begin
         observe(seen);
         check($sformatf("drop_blocked%0d", k), 32'(seen), 32'h0);
         advance(seen);
      end
      req_valid[0] = 1'b0;
      resp_ready   = 1'b1;
      runUntilIdle(20);
      drain();
      check("drop_accepts", 32'(acceptLog.size()), 32'd1);
      check("drop_accept_id", 32'(acceptLog[0]), 32'd1);
      zeroTags = 0;
      foreach (respLog[i]) if (respLog[i] == 0) zeroTags++;
      check("drop_no_tag0", 32'(zeroTags), 32'd0);
      check("drop_resp_count", 32'(respLog.size()), 32'(FILL_DEPTH + 1));

      // One-cycle reset pulse while busy.
      doReset();
      resp_ready = 1'b1;
      applyStimulus(1, 16'h0100);
      applyStimulus(2, 16'hFF00);
      observe(seen);
      tick();
      observe(seen);
      check("rst_busy_before", 32'(resp_valid), 32'h1);
      tick();
      rst        = 1'b1;
      resp_ready = 1'b0;
      applyStimulus(0, 16'h0080);
      acceptLog.delete();
      observe(seen);
      check("rst_ready_zero", 32'(seen), 32'h0);
      tick();
      rst = 1'b0;
      observe(seen);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_data", 32'(resp_data), 32'h0);
      check("rst_first_grant", 32'(seen), 32'b0001);
      advance(seen);
      resp_ready = 1'b1;
      runUntilIdle(20);
      check("rst_first_accept", 32'(acceptLog[0]), 32'd0);
      drain();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
